// File: rtl/rename_regfile.sv
// ============================================================================
// rename_regfile : committed register file + per-register rename (busy/tag)
// Rev 1.0
// ============================================================================
`default_nettype none

module rename_regfile #(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 32,
  parameter int TAG_W    = 4,
  parameter int NUM_RD   = 2,
  parameter int REG_AW   = $clog2(NUM_REGS)
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     rdy_in,
  input  logic                     rob_flush_in,
  input  logic                     disp_en_in,
  input  logic [REG_AW-1:0]        disp_rd_in,
  input  logic [TAG_W-1:0]         disp_tag_in,
  input  logic [NUM_RD*REG_AW-1:0] rd_addr_in,
  output logic [NUM_RD*DATA_W-1:0] rd_data_out,
  output logic [NUM_RD-1:0]        rd_busy_out,
  output logic [NUM_RD*TAG_W-1:0]  rd_tag_out,
  input  logic                     cmt_en_in,
  input  logic [REG_AW-1:0]        cmt_rd_in,
  input  logic [TAG_W-1:0]         cmt_tag_in,
  input  logic [DATA_W-1:0]        cmt_data_in,
  output logic [REG_AW:0]          busy_cnt_out
);

  localparam logic [REG_AW:0] C_NUM_REGS = (REG_AW+1)'(NUM_REGS);

  // Register 0 and indices past the end of the file are never writable.
  function automatic logic idx_ok(input logic [REG_AW-1:0] idx);
    return (idx != '0) && ({1'b0, idx} < C_NUM_REGS);
  endfunction

  logic [DATA_W-1:0] data_q [NUM_REGS];
  logic [DATA_W-1:0] data_d [NUM_REGS];
  logic [TAG_W-1:0]  tag_q  [NUM_REGS];
  logic [TAG_W-1:0]  tag_d  [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [REG_AW:0]     busy_cnt_q, busy_cnt_d;

  logic cmt_ok, disp_ok;

  always_comb begin
    cmt_ok  = rdy_in && cmt_en_in && idx_ok(cmt_rd_in);
    disp_ok = rdy_in && disp_en_in && idx_ok(disp_rd_in) && !rob_flush_in;
    data_d  = data_q;
    tag_d   = tag_q;
    busy_d  = busy_q;
    if (cmt_ok) begin
      data_d[cmt_rd_in] = cmt_data_in;
      if (busy_q[cmt_rd_in] && (tag_q[cmt_rd_in] == cmt_tag_in)) begin
        busy_d[cmt_rd_in] = 1'b0;
        tag_d[cmt_rd_in]  = '0;
      end
    end
    if (rdy_in && rob_flush_in) begin
      busy_d = '0;
      for (int i = 0; i < NUM_REGS; i++) tag_d[i] = '0;
    end
    // Dispatch applied last so it overrides a same-register commit clear.
    if (disp_ok) begin
      busy_d[disp_rd_in] = 1'b1;
      tag_d[disp_rd_in]  = disp_tag_in;
    end
    busy_cnt_d = '0;
    for (int i = 0; i < NUM_REGS; i++) busy_cnt_d = busy_cnt_d + (REG_AW+1)'(busy_d[i]);
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      data_q     <= '{default: '0};
      tag_q      <= '{default: '0};
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      data_q     <= data_d;
      tag_q      <= tag_d;
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign busy_cnt_out = busy_cnt_q;

  generate
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [REG_AW-1:0] addr;
      logic              hit;
      logic [DATA_W-1:0] data;
      logic              busy;
      logic [TAG_W-1:0]  tag;

      always_comb begin
        addr = rd_addr_in[k*REG_AW +: REG_AW];
        hit  = idx_ok(addr);
        data = '0;
        busy = 1'b0;
        tag  = '0;
        if (hit) begin
          data = data_q[addr];
          busy = busy_q[addr];
          tag  = tag_q[addr];
          if (rdy_in && cmt_en_in && (cmt_rd_in == addr)) begin
            data = cmt_data_in;
            if (busy && (tag == cmt_tag_in)) begin
              busy = 1'b0;
              tag  = '0;
            end
          end
        end
      end

      assign rd_data_out[k*DATA_W +: DATA_W] = data;
      assign rd_busy_out[k]                  = busy;
      assign rd_tag_out[k*TAG_W +: TAG_W]    = tag;
    end
  endgenerate

endmodule

`default_nettype wire
